// File: rtl/quire_to_posit.sv
// quire_to_posit: rounds a two's-complement quire word to a posit through a 3-stage valid/ready pipeline
module quire_to_posit #(
    parameter int POSIT_WIDTH        = 8,
    parameter int POSIT_ES           = 0,
    parameter int LOG_NB_ACCUM       = 15,
    parameter bit OUTPUT_ON_EOW_ONLY = 1'b1,
    localparam int QUIRE_SIZE = (2 ** (POSIT_ES + 2)) * (POSIT_WIDTH - 2) + 1 + LOG_NB_ACCUM
) (
    input  logic                   clk,
    input  logic                   rst_n,
    output logic                   rtr_o,
    input  logic                   rts_i,
    input  logic                   sow_i,
    input  logic                   eow_i,
    input  logic [QUIRE_SIZE-1:0]  data_i,
    input  logic                   NaR_i,
    input  logic                   sign_i,
    input  logic                   zero_i,
    input  logic                   rtr_i,
    output logic                   rts_o,
    output logic                   sow_o,
    output logic                   eow_o,
    output logic [POSIT_WIDTH-1:0] posit_o,
    output logic                   NaR_o
);
    localparam int N   = POSIT_WIDTH;
    localparam int ES  = POSIT_ES;
    localparam int QS  = QUIRE_SIZE;
    localparam int BPP = (2 ** (ES + 1)) * (N - 2);
    localparam int PW  = $clog2(QS);
    localparam int SW  = PW + 2;
    localparam int TW  = ES + N + 1;
    localparam int VW  = TW + N + 2;
    localparam logic signed [SW-1:0] MAXS = SW'((2 ** ES) * (N - 2));
    localparam logic [N-1:0] MAXPOS = {1'b0, {(N - 1){1'b1}}};
    localparam logic [N-1:0] MINPOS = N'(1);
    localparam logic [N-1:0] NAR    = {1'b1, {(N - 1){1'b0}}};

    // data_i MSB carries the sign; the separate flag is informational only
    logic unused_sign;
    assign unused_sign = sign_i;

    logic process_en, receive_en;
    logic rtr_o_q, rts_o_q;

    logic          skid_v_q, skid_nar_q, skid_zero_q, skid_sow_q, skid_eow_q;
    logic [QS-1:0] skid_data_q;

    logic          in_v, in_nar, in_zero, in_sow, in_eow, load_d;
    logic [QS-1:0] in_data, mag_d;

    logic          s1_v_q, s1_neg_q, s1_nar_q, s1_zero_q, s1_sow_q, s1_eow_q;
    logic [QS-1:0] s1_mag_q;

    logic [PW-1:0]        lead;
    logic [QS-2:0]        norm;
    logic signed [SW-1:0] scale_d;
    logic [N:0]           frac_d;
    logic                 sticky_d;

    logic                 s2_v_q, s2_neg_q, s2_nar_q, s2_zero_q, s2_sow_q, s2_eow_q, s2_sticky_q;
    logic signed [SW-1:0] s2_scale_q;
    logic [N:0]           s2_frac_q;

    logic signed [SW-1:0] k;
    logic [SW-1:0]        sh;
    logic [TW-1:0]        tail;
    logic signed [VW-1:0] vec, vec_sh;
    logic [N-2:0]         body;
    logic                 guard, rnd;
    logic [N-1:0]         sum, mag_enc, posit_d;

    logic [N-1:0] posit_q;
    logic         nar_q, sow_q, eow_q;

    assign process_en = rtr_i | ~rts_o_q;
    assign receive_en = rts_i & rtr_o_q;

    assign rtr_o   = rtr_o_q;
    assign rts_o   = rts_o_q;
    assign posit_o = posit_q;
    assign NaR_o   = nar_q;
    assign sow_o   = sow_q;
    assign eow_o   = eow_q;

    // ready tracks the pipeline's ability to advance; the skid latch parks one beat caught during a stall
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rtr_o_q     <= 1'b0;
            skid_v_q    <= 1'b0;
            skid_data_q <= '0;
            skid_nar_q  <= 1'b0;
            skid_zero_q <= 1'b0;
            skid_sow_q  <= 1'b0;
            skid_eow_q  <= 1'b0;
        end else begin
            rtr_o_q <= process_en;
            if (process_en) begin
                skid_v_q <= 1'b0;
            end else if (receive_en) begin
                skid_v_q    <= 1'b1;
                skid_data_q <= data_i;
                skid_nar_q  <= NaR_i;
                skid_zero_q <= zero_i;
                skid_sow_q  <= sow_i;
                skid_eow_q  <= eow_i;
            end
        end
    end

    // stage-1 source: latched beat first, else the live input; non-final beats become empty slots when filtering
    always_comb begin
        in_v    = skid_v_q | receive_en;
        in_data = skid_v_q ? skid_data_q : data_i;
        in_nar  = skid_v_q ? skid_nar_q  : NaR_i;
        in_zero = skid_v_q ? skid_zero_q : zero_i;
        in_sow  = skid_v_q ? skid_sow_q  : sow_i;
        in_eow  = skid_v_q ? skid_eow_q  : eow_i;
        mag_d   = in_data[QS-1] ? -in_data : in_data;
        load_d  = in_v & (!OUTPUT_ON_EOW_ONLY | in_eow);
    end

    // stage 1: magnitude (unsigned, so the most negative quire maps to 2^(QS-1)) and flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v_q    <= 1'b0;
            s1_mag_q  <= '0;
            s1_neg_q  <= 1'b0;
            s1_nar_q  <= 1'b0;
            s1_zero_q <= 1'b0;
            s1_sow_q  <= 1'b0;
            s1_eow_q  <= 1'b0;
        end else if (process_en) begin
            s1_v_q <= load_d;
            if (load_d) begin
                s1_mag_q  <= mag_d;
                s1_neg_q  <= in_data[QS-1];
                s1_nar_q  <= in_nar;
                s1_zero_q <= in_zero | (in_data == '0);
                s1_sow_q  <= in_sow;
                s1_eow_q  <= in_eow;
            end
        end
    end

    // leading-one detect, then shift the leading one out of the top so the fraction is left-aligned
    always_comb begin
        lead = '0;
        for (int i = 0; i < QS; i++)
            if (s1_mag_q[i]) lead = PW'(i);
        norm     = (QS - 1)'(s1_mag_q << (PW'(QS - 1) - lead));
        scale_d  = SW'(lead) - SW'(BPP);
        frac_d   = norm[QS-2 -: N+1];
        sticky_d = |norm[QS-N-3:0];
    end

    // stage 2: signed scale, aligned fraction and sticky
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_v_q      <= 1'b0;
            s2_scale_q  <= '0;
            s2_frac_q   <= '0;
            s2_sticky_q <= 1'b0;
            s2_neg_q    <= 1'b0;
            s2_nar_q    <= 1'b0;
            s2_zero_q   <= 1'b0;
            s2_sow_q    <= 1'b0;
            s2_eow_q    <= 1'b0;
        end else if (process_en) begin
            s2_v_q <= s1_v_q;
            if (s1_v_q) begin
                s2_scale_q  <= scale_d;
                s2_frac_q   <= frac_d;
                s2_sticky_q <= sticky_d;
                s2_neg_q    <= s1_neg_q;
                s2_nar_q    <= s1_nar_q;
                s2_zero_q   <= s1_zero_q;
                s2_sow_q    <= s1_sow_q;
                s2_eow_q    <= s1_eow_q;
            end
        end
    end

    // regime built by arithmetic-shifting a "10" (k>=0) or "01" (k<0) head so it fans out into the right run;
    // exponent and fraction trail it, then round-nearest-even and saturate
    always_comb begin
        k       = s2_scale_q >>> ES;
        sh      = k[SW-1] ? ~k : k;
        tail    = TW'({s2_scale_q, s2_frac_q});
        vec     = {~k[SW-1], k[SW-1], tail, {N{1'b0}}};
        vec_sh  = vec >>> sh;
        body    = vec_sh[VW-1 -: N-1];
        guard   = vec_sh[VW-N];
        rnd     = guard & (s2_sticky_q | (|vec_sh[VW-N-1:0]) | body[0]);
        sum     = {1'b0, body} + N'(rnd);
        mag_enc = (s2_scale_q >= MAXS) ? MAXPOS :
                  (s2_scale_q < -MAXS) ? MINPOS :
                  sum[N-1] ? MAXPOS : sum;
        posit_d = s2_nar_q ? NAR : s2_zero_q ? '0 : s2_neg_q ? -mag_enc : mag_enc;
    end

    // stage 3: registered outputs, held while downstream stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rts_o_q <= 1'b0;
            posit_q <= '0;
            nar_q   <= 1'b0;
            sow_q   <= 1'b0;
            eow_q   <= 1'b0;
        end else if (process_en) begin
            rts_o_q <= s2_v_q;
            if (s2_v_q) begin
                posit_q <= posit_d;
                nar_q   <= s2_nar_q;
                sow_q   <= s2_sow_q;
                eow_q   <= s2_eow_q;
            end
        end
    end
endmodule

// File: tb/tb_quire_to_posit.sv
// tb_quire_to_posit: directed bench for quire_to_posit at n=8, es=0, LOG_NB_ACCUM=15
module tb_quire_to_posit;
    localparam int QS = 40;
    localparam int NV = 20;

    typedef struct packed {
        logic [7:0]  p;
        logic        nar;
        logic        sow;
        logic        eow;
        logic [31:0] cyc;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          rts_i = 1'b0, sow_i = 1'b0, eow_i = 1'b0, nar_i = 1'b0, sign_i = 1'b0, zero_i = 1'b0;
    logic          rtr_i = 1'b1;
    logic [QS-1:0] data_i = '0;
    logic          rtr_o, rts_o, sow_o, eow_o, nar_o;
    logic [7:0]    posit_o;
    logic          rtr_o1, rts_o1, sow_o1, eow_o1, nar_o1;
    logic [7:0]    posit_o1;

    int    compared = 0;
    int    mismatched = 0;
    int    stab_bad = 0;
    int    cyc = 0;
    beat_t got[$];
    beat_t got1[$];
    int    acc[$];
    logic  prev_stall = 1'b0;
    logic  [7:0] prev_p = '0;
    logic  prev_nar = 1'b0, prev_eow = 1'b0;
    logic  bp_done = 1'b0;

    logic [QS-1:0] vd [NV] = '{
        40'h00_0000_1000, 40'hFF_FFFF_F000, 40'h00_0000_1800, 40'h00_0000_1040, 40'h00_0000_10C0,
        40'h00_0000_1041, 40'h01_0000_0000, 40'h00_0000_0001, 40'hFF_FFFF_FFFF, 40'h80_0000_0000,
        40'h00_0000_2000, 40'h00_0000_0800, 40'h00_0000_3000, 40'h00_0000_0020, 40'h00_0000_0060,
        40'h00_0003_8000, 40'hFF_FFFF_E800, 40'h00_0003_0000, 40'h00_0002_0000, 40'h00_0000_0040
    };
    logic [7:0] ve [NV] = '{
        8'h40, 8'hC0, 8'h50, 8'h40, 8'h42,
        8'h41, 8'h7F, 8'h01, 8'hFF, 8'h81,
        8'h60, 8'h20, 8'h68, 8'h01, 8'h02,
        8'h7F, 8'hB0, 8'h7E, 8'h7E, 8'h01
    };

    quire_to_posit #(.POSIT_WIDTH(8), .POSIT_ES(0), .LOG_NB_ACCUM(15), .OUTPUT_ON_EOW_ONLY(1'b1)) u0 (
        .clk(clk), .rst_n(rst_n), .rtr_o(rtr_o), .rts_i(rts_i), .sow_i(sow_i), .eow_i(eow_i),
        .data_i(data_i), .NaR_i(nar_i), .sign_i(sign_i), .zero_i(zero_i), .rtr_i(rtr_i),
        .rts_o(rts_o), .sow_o(sow_o), .eow_o(eow_o), .posit_o(posit_o), .NaR_o(nar_o)
    );

    quire_to_posit #(.POSIT_WIDTH(8), .POSIT_ES(0), .LOG_NB_ACCUM(15), .OUTPUT_ON_EOW_ONLY(1'b0)) u1 (
        .clk(clk), .rst_n(rst_n), .rtr_o(rtr_o1), .rts_i(rts_i), .sow_i(sow_i), .eow_i(eow_i),
        .data_i(data_i), .NaR_i(nar_i), .sign_i(sign_i), .zero_i(zero_i), .rtr_i(1'b1),
        .rts_o(rts_o1), .sow_o(sow_o1), .eow_o(eow_o1), .posit_o(posit_o1), .NaR_o(nar_o1)
    );

    always #5 clk = ~clk;

    // inputs change just after posedge, so the negedge sees exactly what the next posedge will sample
    always @(negedge clk) begin
        if (rst_n && rts_i && rtr_o) acc.push_back(cyc);
        if (rst_n && rts_o && rtr_i) got.push_back('{posit_o, nar_o, sow_o, eow_o, 32'(cyc)});
        if (rst_n && rts_o1) got1.push_back('{posit_o1, nar_o1, sow_o1, eow_o1, 32'(cyc)});
        if (prev_stall && rst_n && !(rts_o && posit_o == prev_p && nar_o == prev_nar && eow_o == prev_eow))
            stab_bad++;
        prev_stall = rst_n && rts_o && !rtr_i;
        prev_p     = posit_o;
        prev_nar   = nar_o;
        prev_eow   = eow_o;
        cyc++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [QS-1:0] d, input logic nr, input logic z, input logic s, input logic e);
        rts_i = 1'b1; data_i = d; nar_i = nr; zero_i = z; sow_i = s; eow_i = e; sign_i = d[QS-1];
        for (int t = 0; t <= 200; t++) begin
            @(negedge clk);
            if (rtr_o) break;
            if (t == 200) chk("send_timeout", 64'(rtr_o), 64'd1);
        end
        @(posedge clk);
        #1;
        rts_i = 1'b0; sow_i = 1'b0; eow_i = 1'b0; nar_i = 1'b0; zero_i = 1'b0;
    endtask

    task automatic drain(input int n);
        for (int t = 0; t < 200 && got.size() < n; t++) @(negedge clk);
        repeat (4) @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic vec(input string tag, input logic [QS-1:0] d, input logic nr, input logic z,
                       input logic [7:0] ep, input logic en);
        got.delete();
        acc.delete();
        send(d, nr, z, 1'b1, 1'b1);
        drain(1);
        chk({tag, "_cnt"}, 64'(got.size()), 64'd1);
        if (got.size() > 0 && acc.size() > 0) begin
            chk({tag, "_posit"}, 64'(got[0].p), 64'(ep));
            chk({tag, "_nar"}, 64'(got[0].nar), 64'(en));
            chk({tag, "_sow"}, 64'(got[0].sow), 64'd1);
            chk({tag, "_eow"}, 64'(got[0].eow), 64'd1);
            chk({tag, "_lat"}, 64'(got[0].cyc - 32'(acc[0])), 64'd3);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_rts", 64'(rts_o), 64'd0);
        chk("rst_rtr", 64'(rtr_o), 64'd0);
        chk("rst_posit", 64'(posit_o), 64'd0);
        chk("rst_nar", 64'(nar_o), 64'd0);
        chk("rst_sow_eow", 64'({sow_o, eow_o}), 64'd0);
        chk("rst_rts1", 64'(rts_o1), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rtr_after_rst", 64'(rtr_o), 64'd1);

        for (int i = 0; i < NV; i++) vec($sformatf("vec%0d", i), vd[i], 1'b0, 1'b0, ve[i], 1'b0);
        vec("zero_flag", 40'h00_0000_1000, 1'b0, 1'b1, 8'h00, 1'b0);
        vec("zero_data", 40'h00_0000_0000, 1'b0, 1'b0, 8'h00, 1'b0);
        vec("nar", 40'h00_0000_1000, 1'b1, 1'b0, 8'h80, 1'b1);
        vec("nar_zero", 40'h00_0000_0000, 1'b1, 1'b1, 8'h80, 1'b1);

        got.delete();
        got1.delete();
        for (int i = 0; i < 5; i++) send(vd[i], 1'b0, 1'b0, i == 0, i == 4);
        drain(1);
        chk("filt_cnt", 64'(got.size()), 64'd1);
        if (got.size() > 0) begin
            chk("filt_posit", 64'(got[0].p), 64'(ve[4]));
            chk("filt_eow", 64'(got[0].eow), 64'd1);
            chk("filt_sow", 64'(got[0].sow), 64'd0);
        end
        chk("nofilt_cnt", 64'(got1.size()), 64'd5);
        for (int i = 0; i < got1.size() && i < 5; i++) begin
            chk($sformatf("nofilt_posit%0d", i), 64'(got1[i].p), 64'(ve[i]));
            chk($sformatf("nofilt_eow%0d", i), 64'(got1[i].eow), 64'(i == 4));
        end
        if (got1.size() == 5) chk("nofilt_tput", 64'(got1[4].cyc - got1[0].cyc), 64'd4);

        got.delete();
        stab_bad = 0;
        bp_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 200; i++) send(vd[i % NV], 1'b0, 1'b0, (i % 3) == 0, 1'b1);
                bp_done = 1'b1;
            end
            begin
                for (int t = 0; t < 4000 && !(bp_done && got.size() >= 200); t++) begin
                    @(posedge clk);
                    #1;
                    rtr_i = 1'($urandom_range(0, 1));
                end
                rtr_i = 1'b1;
            end
        join
        drain(200);
        chk("bp_cnt", 64'(got.size()), 64'd200);
        for (int i = 0; i < got.size() && i < 200; i++) begin
            chk($sformatf("bp_posit%0d", i), 64'(got[i].p), 64'(ve[i % NV]));
            chk($sformatf("bp_sow%0d", i), 64'(got[i].sow), 64'((i % 3) == 0));
        end
        chk("bp_stable", 64'(stab_bad), 64'd0);

        got.delete();
        for (int i = 0; i < 3; i++) send(vd[i], 1'b0, 1'b0, 1'b0, 1'b1);
        chk("inflight_rts", 64'(rts_o), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_rts", 64'(rts_o), 64'd0);
        chk("midrst_rtr", 64'(rtr_o), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("midrst_stale", 64'(got.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
